// File: rtl/sobel_window_buffer_if.sv
// rtl/sobel_window_buffer_if.sv - pixel stream in, three-row tap stream out
interface sobel_window_buffer_if;
   logic        sof;
   logic        pix_valid;
   logic [11:0] pix_in;
   logic [33:0] tap_top;
   logic [33:0] tap_mid;
   logic [33:0] tap_bot;
   logic        tap_valid;
   logic        window_ok;
   logic        frame_done;
   logic        resync;

   modport master (
      output sof, pix_valid, pix_in,
      input  tap_top, tap_mid, tap_bot, tap_valid, window_ok, frame_done, resync
   );

   modport slave (
      input  sof, pix_valid, pix_in,
      output tap_top, tap_mid, tap_bot, tap_valid, window_ok, frame_done, resync
   );
endinterface

// File: rtl/sobel_window_buffer.sv
// rtl/sobel_window_buffer.sv - two-line buffer producing coordinate-tagged 3-row taps
module sobel_window_buffer #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
) (
   input  logic                  clk,
   input  logic                  rst_n,
   sobel_window_buffer_if.slave  bus
);
   localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam logic [10:0] X_LAST = 11'(IMG_WIDTH - 1);
   localparam logic [10:0] Y_LAST = 11'(IMG_HEIGHT - 1);

   typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

   state_t      state_q, state_d;
   logic [10:0] x_q, x_d, y_q, y_d;
   logic [10:0] tag_x, tag_y;
   logic        accept, at_eol, last, resync_d;

   logic [11:0] line1 [IMG_WIDTH];
   logic [11:0] line2 [IMG_WIDTH];
   logic [11:0] old1, old2;
   logic [AW-1:0] col;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
      end
   end

   // sof overrides the counters so the pixel carrying it is always (0,0)
   always_comb begin
      accept   = bus.pix_valid & (bus.sof | (state_q != IDLE));
      tag_x    = bus.sof ? 11'd0 : x_q;
      tag_y    = bus.sof ? 11'd0 : y_q;
      at_eol   = (tag_x == X_LAST);
      last     = ~bus.sof & at_eol & (tag_y == Y_LAST);
      resync_d = accept & bus.sof & (state_q != IDLE);
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      if (accept) begin
         if (last) begin
            x_d     = '0;
            y_d     = '0;
            state_d = IDLE;
         end else if (at_eol) begin
            x_d     = '0;
            y_d     = tag_y + 11'd1;
            state_d = (tag_y != 11'd0) ? STREAM : FILL;
         end else begin
            x_d     = tag_x + 11'd1;
            y_d     = tag_y;
            state_d = bus.sof ? FILL : state_q;
         end
      end
   end

   assign col  = tag_x[AW-1:0];
   assign old1 = line1[col];
   assign old2 = line2[col];

   // line memories carry no reset; rows not yet written are masked by tag_y
   always_ff @(posedge clk) begin
      if (accept) begin
         line1[col] <= bus.pix_in;
         line2[col] <= old1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.tap_top    <= '0;
         bus.tap_mid    <= '0;
         bus.tap_bot    <= '0;
         bus.tap_valid  <= 1'b0;
         bus.window_ok  <= 1'b0;
         bus.frame_done <= 1'b0;
         bus.resync     <= 1'b0;
      end else begin
         bus.tap_valid  <= accept;
         bus.frame_done <= accept & last;
         bus.resync     <= resync_d;
         if (accept) begin
            bus.tap_bot   <= {tag_y, tag_x, bus.pix_in};
            bus.tap_mid   <= (tag_y >= 11'd1) ? {tag_y - 11'd1, tag_x, old1} : 34'h0;
            bus.tap_top   <= (tag_y >= 11'd2) ? {tag_y - 11'd2, tag_x, old2} : 34'h0;
            bus.window_ok <= (tag_y >= 11'd2);
         end
      end
   end
endmodule

// File: tb/tb_sobel_window_buffer.sv
// tb/tb_sobel_window_buffer.sv - directed self-checking bench for sobel_window_buffer
module tb_sobel_window_buffer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   failed = 0;

   sobel_window_buffer_if bus ();

   sobel_window_buffer #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // bench view of the frame: pixel sent at each tagged position
   int   fp [4][4];
   int   bx, by;
   bit   b_active;
   logic [33:0] p_bot, p_mid, p_top;
   logic        p_ok;

   function automatic logic [33:0] tw(input int y, input int x, input int p);
      return {11'(y), 11'(x), 12'(p)};
   endfunction

   task automatic chk(input string name, input logic [33:0] obs, input logic [33:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", name, obs, exp);
      end
   endtask

   task automatic chk_zero(input string name);
      chk({name, ".tap_top"},    bus.tap_top, 34'h0);
      chk({name, ".tap_mid"},    bus.tap_mid, 34'h0);
      chk({name, ".tap_bot"},    bus.tap_bot, 34'h0);
      chk({name, ".tap_valid"},  34'(bus.tap_valid), 34'h0);
      chk({name, ".window_ok"},  34'(bus.window_ok), 34'h0);
      chk({name, ".frame_done"}, 34'(bus.frame_done), 34'h0);
      chk({name, ".resync"},     34'(bus.resync), 34'h0);
   endtask

   task automatic model_reset();
      bx = 0; by = 0; b_active = 1'b0;
      p_bot = '0; p_mid = '0; p_top = '0; p_ok = 1'b0;
   endtask

   task automatic px(input bit s, input bit v, input int p);
      bit acc, lst, rs;
      int tx, ty;
      acc = v && (s || b_active);
      lst = 1'b0;
      rs  = 1'b0;
      @(negedge clk);
      bus.sof = s; bus.pix_valid = v; bus.pix_in = 12'(p);
      @(posedge clk);
      #1;
      if (acc) begin
         tx = s ? 0 : bx;
         ty = s ? 0 : by;
         rs = s && b_active;
         fp[ty][tx] = p;
         lst = !s && tx == 3 && ty == 3;
         p_bot = tw(ty, tx, p);
         p_mid = (ty >= 1) ? tw(ty - 1, tx, fp[ty-1][tx]) : 34'h0;
         p_top = (ty >= 2) ? tw(ty - 2, tx, fp[ty-2][tx]) : 34'h0;
         p_ok  = (ty >= 2);
         if (lst) begin
            bx = 0; by = 0; b_active = 1'b0;
         end else begin
            b_active = 1'b1;
            bx = (tx == 3) ? 0 : tx + 1;
            by = (tx == 3) ? ty + 1 : ty;
         end
      end
      chk("tap_valid",  34'(bus.tap_valid), 34'(acc));
      chk("tap_bot",    bus.tap_bot, p_bot);
      chk("tap_mid",    bus.tap_mid, p_mid);
      chk("tap_top",    bus.tap_top, p_top);
      chk("window_ok",  34'(bus.window_ok), 34'(p_ok));
      chk("frame_done", 34'(bus.frame_done), 34'(lst));
      chk("resync",     34'(bus.resync), 34'(rs));
   endtask

   initial begin
      bus.sof = 1'b0; bus.pix_valid = 1'b0; bus.pix_in = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // idle pixel without sof is dropped
      px(0, 1, 99);

      // continuous frame
      for (int i = 0; i < 16; i++) begin
         px(i == 0, 1, 10 * (i / 4) + i % 4);
         if (i == 3) begin
            chk("fill30.mid", bus.tap_mid, 34'h0);
            chk("fill30.top", bus.tap_top, 34'h0);
         end
         if (i == 5) begin
            chk("fill11.bot", bus.tap_bot, 34'h080100B);
            chk("fill11.mid", bus.tap_mid, 34'h0001001);
            chk("fill11.top", bus.tap_top, 34'h0);
            chk("fill11.ok",  34'(bus.window_ok), 34'h0);
         end
         if (i == 10) begin
            chk("s22.bot", bus.tap_bot, 34'h1002016);
            chk("s22.mid", bus.tap_mid, 34'h080200C);
            chk("s22.top", bus.tap_top, 34'h0002002);
            chk("s22.ok",  34'(bus.window_ok), 34'h1);
         end
      end

      // gapped frame: every other cycle idle
      for (int i = 0; i < 16; i++) begin
         px(i == 0, 1, 10 * (i / 4) + i % 4);
         if (i == 15) begin
            chk("last.done", 34'(bus.frame_done), 34'h1);
            chk("last.bot",  bus.tap_bot, 34'h1803021);
         end
         px(0, 0, 0);
      end

      // back in IDLE: three pixels without sof are dropped
      for (int k = 0; k < 3; k++) px(0, 1, 40 + k);
      px(1, 1, 5);
      chk("sof5.bot", bus.tap_bot, 34'h5);

      // run to (1,2), then sof mid-frame
      for (int i = 1; i < 9; i++) px(0, 1, 10 * (i / 4) + i % 4);
      px(1, 1, 0);
      chk("midsof.resync", 34'(bus.resync), 34'h1);
      chk("midsof.bot",    bus.tap_bot, 34'h0);
      for (int i = 1; i < 10; i++) px(0, 1, 10 * (i / 4) + i % 4);

      // asynchronous reset pulse during STREAM
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_zero("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      px(0, 1, 7);

      // sof coinciding with the last-pixel position wins
      for (int i = 0; i < 15; i++) px(i == 0, 1, 10 * (i / 4) + i % 4);
      px(1, 1, 0);
      chk("soflast.done",   34'(bus.frame_done), 34'h0);
      chk("soflast.resync", 34'(bus.resync), 34'h1);
      for (int i = 1; i < 16; i++) px(0, 1, 10 * (i / 4) + i % 4);
      chk("end.done", 34'(bus.frame_done), 34'h1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
